// File: rtl/sram_arb_pkg.sv
// Shared types for the two-requester SRAM port arbiter: requester id, count, mode.
package sram_arb_pkg;

    localparam int unsigned NUM_REQ = 2;

    typedef logic [0:0] req_id_t;

    typedef enum logic {
        MODE_RR    = 1'b0,
        MODE_FIXED = 1'b1
    } prio_mode_e;

endpackage

// File: rtl/sram_port_arbiter_if.sv
// Requester handshakes plus the SRAM-side bus; slave is the arbiter view, master the driver view.
interface sram_port_arbiter_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4
);
    logic                  r0_valid, r0_ready, r0_we, r0_rvalid;
    logic [ADDR_WIDTH-1:0] r0_addr;
    logic [DATA_WIDTH-1:0] r0_wdata, r0_rdata;
    logic                  r1_valid, r1_ready, r1_we, r1_rvalid;
    logic [ADDR_WIDTH-1:0] r1_addr;
    logic [DATA_WIDTH-1:0] r1_wdata, r1_rdata;
    logic                  mem_we_n;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_din, mem_dout;

    modport slave (
        input  r0_valid, r0_we, r0_addr, r0_wdata,
        input  r1_valid, r1_we, r1_addr, r1_wdata,
        input  mem_dout,
        output r0_ready, r0_rvalid, r0_rdata,
        output r1_ready, r1_rvalid, r1_rdata,
        output mem_we_n, mem_addr, mem_din
    );

    modport master (
        output r0_valid, r0_we, r0_addr, r0_wdata,
        output r1_valid, r1_we, r1_addr, r1_wdata,
        output mem_dout,
        input  r0_ready, r0_rvalid, r0_rdata,
        input  r1_ready, r1_rvalid, r1_rdata,
        input  mem_we_n, mem_addr, mem_din
    );
endinterface

// File: rtl/sram_rr_pick.sv
// Grant selection: valids, mode and round-robin pointer to a one-hot grant.
module sram_rr_pick
    import sram_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] valid_i,
    input  prio_mode_e         mode_i,
    input  req_id_t            ptr_i,
    output logic [NUM_REQ-1:0] grant_o
);

    always_comb begin
        grant_o = '0;
        if (&valid_i) begin
            if (mode_i == MODE_FIXED || ptr_i == 1'b0) grant_o = 2'b01;
            else                                       grant_o = 2'b10;
        end else begin
            grant_o = valid_i;
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Two-requester arbiter onto a single registered-read SRAM port, with one-cycle read return.
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                prio_mode,
    sram_port_arbiter_if.slave  bus
);

    logic [NUM_REQ-1:0]    valid, grant, ready;
    req_id_t               ptr_q, ptr_d, rd_id_q, rd_id_d, sel;
    logic                  rd_vld_q, rd_vld_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d, sel_addr;
    logic [DATA_WIDTH-1:0] din_q, din_d, sel_wdata;
    logic                  xfer, sel_we;

    assign valid = {bus.r1_valid, bus.r0_valid};

    sram_rr_pick u_pick (
        .valid_i (valid),
        .mode_i  (prio_mode_e'(prio_mode)),
        .ptr_i   (ptr_q),
        .grant_o (grant)
    );

    // Ready is gated by rstn directly so nothing is accepted while reset is held.
    assign ready = grant & {NUM_REQ{rstn}};
    assign xfer  = |ready;

    always_comb begin
        sel       = ready[1];
        sel_we    = ready[1] ? bus.r1_we    : bus.r0_we;
        sel_addr  = ready[1] ? bus.r1_addr  : bus.r0_addr;
        sel_wdata = ready[1] ? bus.r1_wdata : bus.r0_wdata;
        ptr_d     = ptr_q;
        addr_d    = addr_q;
        din_d     = din_q;
        rd_vld_d  = xfer & ~sel_we;
        rd_id_d   = sel;
        if (xfer) begin
            ptr_d  = ~sel;
            addr_d = sel_addr;
            din_d  = sel_wdata;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr_q    <= '0;
            rd_vld_q <= 1'b0;
            rd_id_q  <= '0;
            addr_q   <= '0;
            din_q    <= '0;
        end else begin
            ptr_q    <= ptr_d;
            rd_vld_q <= rd_vld_d;
            rd_id_q  <= rd_id_d;
            addr_q   <= addr_d;
            din_q    <= din_d;
        end
    end

    assign bus.r0_ready  = ready[0];
    assign bus.r1_ready  = ready[1];
    assign bus.mem_we_n  = xfer ? ~sel_we : 1'b1;
    assign bus.mem_addr  = xfer ? sel_addr : addr_q;
    assign bus.mem_din   = xfer ? sel_wdata : din_q;

    assign bus.r0_rvalid = rd_vld_q & (rd_id_q == 1'b0);
    assign bus.r1_rvalid = rd_vld_q & (rd_id_q == 1'b1);
    assign bus.r0_rdata  = bus.r0_rvalid ? bus.mem_dout : '0;
    assign bus.r1_rdata  = bus.r1_rvalid ? bus.mem_dout : '0;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench: stimulus pushes expected read returns, a negedge monitor pops and compares.
module tb_sram_port_arbiter;

    typedef struct packed {
        logic       id;
        logic [7:0] data;
    } rd_exp_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic prio_mode = 1'b0;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    rd_exp_t    exp_q[$];
    logic [7:0] exp_mem [16];
    logic [7:0] sram [16];
    logic [3:0] last_a;
    logic [7:0] last_d;

    sram_port_arbiter_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus ();

    sram_port_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .prio_mode (prio_mode),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    // External SRAM: synchronous write, registered read data.
    always @(posedge clk) begin
        if (!bus.mem_we_n) sram[bus.mem_addr] <= bus.mem_din;
        bus.mem_dout <= sram[bus.mem_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        rd_exp_t e;
        if (bus.r0_rvalid || bus.r1_rvalid) begin
            check("rvalid_onehot", {30'd0, bus.r1_rvalid, bus.r0_rvalid} & 32'h3 , bus.r1_rvalid ? 32'h2 : 32'h1);
            if (exp_q.size() == 0) begin
                check("unexpected_rvalid", {30'd0, bus.r1_rvalid, bus.r0_rvalid}, 32'h0);
            end else begin
                e = exp_q.pop_front();
                check("rvalid_id", {31'd0, bus.r1_rvalid}, {31'd0, e.id});
                check("rdata", {24'd0, bus.r1_rvalid ? bus.r1_rdata : bus.r0_rdata}, {24'd0, e.data});
            end
        end else begin
            check("rdata_idle_zero", {16'd0, bus.r1_rdata, bus.r0_rdata}, 32'h0);
        end
    end

    task automatic drive(input logic v0, input logic w0, input logic [3:0] a0, input logic [7:0] d0,
                         input logic v1, input logic w1, input logic [3:0] a1, input logic [7:0] d1);
        bus.r0_valid = v0; bus.r0_we = w0; bus.r0_addr = a0; bus.r0_wdata = d0;
        bus.r1_valid = v1; bus.r1_we = w1; bus.r1_addr = a1; bus.r1_wdata = d1;
    endtask

    // One cycle: drive, check grant and SRAM bus at negedge, record expected read, advance.
    task automatic step(input logic v0, input logic w0, input logic [3:0] a0, input logic [7:0] d0,
                        input logic v1, input logic w1, input logic [3:0] a1, input logic [7:0] d1,
                        input logic [1:0] eg, input logic keep);
        logic       we;
        logic [3:0] a;
        logic [7:0] d;
        drive(v0, w0, a0, d0, v1, w1, a1, d1);
        @(negedge clk);
        check("ready", {30'd0, bus.r1_ready, bus.r0_ready}, {30'd0, eg});
        if (eg != 2'b00) begin
            we = eg[1] ? w1 : w0;
            a  = eg[1] ? a1 : a0;
            d  = eg[1] ? d1 : d0;
            check("mem_we_n", {31'd0, bus.mem_we_n}, {31'd0, ~we});
            check("mem_addr", {28'd0, bus.mem_addr}, {28'd0, a});
            check("mem_din", {24'd0, bus.mem_din}, {24'd0, d});
            last_a = a;
            last_d = d;
            if (we) exp_mem[a] = d;
            else if (keep) exp_q.push_back('{id: eg[1], data: exp_mem[a]});
        end else begin
            check("idle_we_n", {31'd0, bus.mem_we_n}, 32'h1);
            check("idle_addr", {28'd0, bus.mem_addr}, {28'd0, last_a});
            check("idle_din", {24'd0, bus.mem_din}, {24'd0, last_d});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state();
        @(negedge clk);
        check("rst_ready", {30'd0, bus.r1_ready, bus.r0_ready}, 32'h0);
        check("rst_we_n", {31'd0, bus.mem_we_n}, 32'h1);
        check("rst_addr", {28'd0, bus.mem_addr}, 32'h0);
        check("rst_din", {24'd0, bus.mem_din}, 32'h0);
        check("rst_rvalid", {30'd0, bus.r1_rvalid, bus.r0_rvalid}, 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 16; i++) begin
            sram[i]    = 8'h00;
            exp_mem[i] = 8'h00;
        end
        last_a = '0;
        last_d = '0;
        drive(1, 1, 4'h3, 8'h77, 1, 0, 4'h1, 8'h00);
        check_reset_state();
        @(posedge clk);
        #1;
        rstn = 1'b1;

        // Single requester write then read, accepted on first edge after reset.
        step(1, 1, 4'h3, 8'hA5, 0, 0, 4'h0, 8'h00, 2'b01, 1);
        step(1, 0, 4'h3, 8'h00, 0, 0, 4'h0, 8'h00, 2'b01, 1);
        step(0, 1, 4'h0, 8'h00, 1, 1, 4'h0, 8'h11, 2'b10, 1);
        step(1, 1, 4'h1, 8'h22, 0, 0, 4'h0, 8'h00, 2'b01, 1);

        // Round-robin contention: pointer is at r1 here.
        step(1, 0, 4'h0, 8'h00, 1, 0, 4'h1, 8'h00, 2'b10, 1);
        step(1, 0, 4'h0, 8'h00, 1, 0, 4'h1, 8'h00, 2'b01, 1);
        step(1, 0, 4'h0, 8'h00, 1, 0, 4'h1, 8'h00, 2'b10, 1);
        step(1, 0, 4'h0, 8'h00, 1, 0, 4'h1, 8'h00, 2'b01, 1);

        // Fixed priority: r0 wins although the pointer favours r1.
        prio_mode = 1'b1;
        for (int i = 0; i < 3; i++)
            step(1, 0, 4'h0, 8'h00, 1, 0, 4'h1, 8'h00, 2'b01, 1);
        prio_mode = 1'b0;

        // Write by r1 then read by r0 of the same address.
        step(0, 0, 4'h0, 8'h00, 1, 1, 4'hF, 8'h3C, 2'b10, 1);
        step(1, 0, 4'hF, 8'h00, 0, 0, 4'h0, 8'h00, 2'b01, 1);

        // Pointer hold across idle cycles.
        step(0, 0, 4'h0, 8'h00, 1, 0, 4'h1, 8'h00, 2'b10, 1);
        for (int i = 0; i < 3; i++)
            step(0, 0, 4'h0, 8'h00, 0, 0, 4'h0, 8'h00, 2'b00, 1);
        step(1, 0, 4'h0, 8'h00, 1, 0, 4'h1, 8'h00, 2'b01, 1);

        // Reset right after a read is accepted: its return must be dropped.
        step(1, 0, 4'hF, 8'h00, 0, 0, 4'h0, 8'h00, 2'b01, 0);
        rstn = 1'b0;
        drive(1, 0, 4'h3, 8'h00, 1, 0, 4'h1, 8'h00);
        last_a = '0;
        last_d = '0;
        check_reset_state();
        @(posedge clk);
        #1;
        rstn = 1'b1;
        step(1, 0, 4'h3, 8'h00, 1, 0, 4'h1, 8'h00, 2'b01, 1);

        for (int i = 0; i < 3; i++)
            step(0, 0, 4'h0, 8'h00, 0, 0, 4'h0, 8'h00, 2'b00, 1);
        check("pending_reads", exp_q.size(), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sram_port_arbiter.md
SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, SRAM word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4, SRAM address width in bits.
REQ-003 SHALL have port clk  input  1  clock; all state changes on posedge.
REQ-004 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port prio_mode  input  1  0 = round-robin, 1 = fixed priority (requester 0 wins).
REQ-006 SHALL have, for each requester n in {0,1}, port rn_valid  input  1  request present.
REQ-007 SHALL have port rn_ready  output  1  request accepted this cycle.
REQ-008 SHALL have port rn_we  input  1  1 = write, 0 = read.
REQ-009 SHALL have port rn_addr  input  ADDR_WIDTH  word address.
REQ-010 SHALL have port rn_wdata  input  DATA_WIDTH  write data.
REQ-011 SHALL have port rn_rvalid  output  1  read data valid, one-cycle pulse.
REQ-012 SHALL have port rn_rdata  output  DATA_WIDTH  read data.
REQ-013 SHALL have port mem_we_n  output  1  SRAM active-low write enable.
REQ-014 SHALL have port mem_addr  output  ADDR_WIDTH  SRAM address.
REQ-015 SHALL have port mem_din  output  DATA_WIDTH  SRAM write data.
REQ-016 SHALL have port mem_dout  input  DATA_WIDTH  SRAM registered read data.

Function
REQ-017 SHALL accept at most one request per cycle; a transfer occurs when rn_valid and rn_ready are both 1.
REQ-018 SHALL compute rn_ready combinationally from valids, prio_mode and the RR pointer; rn_ready SHALL be 0 when rn_valid is 0.
REQ-019 SHALL, with a single valid requester, grant it in the same cycle; there is no idle bubble.
REQ-020 SHALL, in round-robin mode with both valid, grant the requester indicated by the 1-bit pointer.
REQ-021 SHALL, after each transfer, set the pointer to the non-granted requester; the pointer SHALL hold when no transfer occurs.
REQ-022 SHALL, in fixed mode with both valid, grant requester 0; the pointer SHALL still update per REQ-021.
REQ-023 SHALL drive mem_addr/mem_din from the granted requester combinationally, with mem_we_n = ~rn_we on a transfer and 1 otherwise.
REQ-024 SHALL, when idle, hold mem_we_n=1 with mem_addr/mem_din equal to the last granted values; these values SHALL be 0 after reset.
REQ-025 SHALL, for a read accepted in cycle T, assert rn_rvalid to that requester only in cycle T+1 with rn_rdata = mem_dout.
REQ-026 SHALL track the in-flight read in a registered {valid, requester id} stage; back-to-back reads SHALL each return exactly one cycle after acceptance.
REQ-027 SHALL produce no rvalid for writes.
REQ-028 SHALL return, for a write in T followed by a read to the same address in T+1, the new data in T+2.
REQ-029 SHALL drive rn_rdata = mem_dout whenever rn_rvalid is 1, and 0 otherwise.
REQ-030 SHALL take a prio_mode change effect in the same cycle; in-flight reads are unaffected.

Reset
REQ-031 SHALL, while rstn=0, force the pointer to requester 0, in-flight valid to 0, all rvalid to 0, all ready to 0, and mem_we_n to 1.
REQ-032 SHALL discard a read accepted in the cycle before reset assertion; no rvalid SHALL appear after release.
REQ-033 SHALL permit acceptance on the first posedge after rstn deasserts.

Structure
REQ-034 SHALL place the requester-id type, the requester count (2) and the mode encoding in package sram_arb_pkg.
REQ-035 SHALL isolate the grant logic (valids, mode, pointer -> one-hot grant) in sub-module sram_rr_pick; the SRAM itself stays outside this block.

Verification
REQ-036 SHALL cover a single-requester case: r0 write addr 3 = 0xA5, then r0 read addr 3 -> r0_rvalid one cycle after acceptance with 0xA5, r1_rvalid stays 0.
REQ-037 SHALL cover round-robin contention: both requesters issue continuous reads, prio_mode=0 -> grants alternate r0,r1,r0,r1 and each rvalid lands on its own requester.
REQ-038 SHALL cover fixed-priority mode: prio_mode=1 with both continuously valid -> r0 granted every cycle, r1_ready stays 0.
REQ-039 SHALL cover a read-after-write across requesters: r1 writes addr 0xF = 0x3C in T, r0 reads 0xF in T+1 -> r0_rdata=0x3C in T+2.
REQ-040 SHALL cover reset mid-read: read accepted, then rstn low next cycle -> no rvalid, pointer back to 0, mem_we_n=1.
REQ-041 SHALL cover pointer hold: r1 granted, then idle 3 cycles, then both valid -> r0 granted.
